// File: rtl/branch_predict_unit.sv
// Branch prediction/resolution unit: direct-mapped BTB with 2-bit counters, execute-side
// mispredict detection and table training. Define BP_STATS_EN to enable the stat counters.
module branch_predict_unit #(
   parameter int unsigned PC_W      = 32,
   parameter int unsigned ENTRIES   = 16,
   parameter int unsigned CTR_ALLOC = 2
) (
   input  logic            clock,
   input  logic            reset,
   input  logic [PC_W-1:0] f_pc,
   output logic            f_pred_taken,
   output logic [PC_W-1:0] f_pred_target,
   input  logic            x_valid,
   input  logic [PC_W-1:0] x_pc,
   input  logic            x_uncond,
   input  logic            x_taken,
   input  logic [PC_W-1:0] x_target,
   input  logic            x_pred_taken,
   input  logic [PC_W-1:0] x_pred_target,
   input  logic            stall,
   output logic            mispredict,
   output logic [PC_W-1:0] redirect_pc,
   output logic [31:0]     stat_branches,
   output logic [31:0]     stat_mispredicts
);

   localparam int unsigned IDX_W = $clog2(ENTRIES);
   localparam int unsigned TAG_W = PC_W - IDX_W;

   logic             valid_q  [ENTRIES];
   logic [TAG_W-1:0] tag_q    [ENTRIES];
   logic [PC_W-1:0]  target_q [ENTRIES];
   logic             uncond_q [ENTRIES];
   logic [1:0]       ctr_q    [ENTRIES];

   logic [IDX_W-1:0] f_idx, x_idx;
   logic [TAG_W-1:0] f_tag, x_tag;
   logic             f_hit, x_hit;
   logic             do_update;

   assign f_idx = f_pc[IDX_W-1:0];
   assign f_tag = f_pc[PC_W-1:IDX_W];
   assign x_idx = x_pc[IDX_W-1:0];
   assign x_tag = x_pc[PC_W-1:IDX_W];

   // Fetch lookup reads the registered table, so a same-cycle update is not visible yet.
   assign f_hit         = valid_q[f_idx] && (tag_q[f_idx] == f_tag);
   assign f_pred_taken  = f_hit && (uncond_q[f_idx] || ctr_q[f_idx][1]);
   assign f_pred_target = f_pred_taken ? target_q[f_idx] : f_pc + PC_W'(1);

   assign mispredict  = x_valid && ((x_taken != x_pred_taken) ||
                                    (x_taken && (x_target != x_pred_target)));
   assign redirect_pc = (x_valid && x_taken) ? x_target : x_pc + PC_W'(1);

   assign x_hit     = valid_q[x_idx] && (tag_q[x_idx] == x_tag);
   assign do_update = x_valid && !stall;

   always_ff @(posedge clock) begin
      if (reset) begin
         for (int unsigned i = 0; i < ENTRIES; i++) begin
            valid_q[i] <= 1'b0;
            ctr_q[i]   <= 2'd1;
         end
      end else if (do_update) begin
         if (x_hit) begin
            if (x_taken) begin
               if (ctr_q[x_idx] != 2'd3) ctr_q[x_idx] <= ctr_q[x_idx] + 2'd1;
               target_q[x_idx] <= x_target;
               uncond_q[x_idx] <= x_uncond;
            end else if (ctr_q[x_idx] != 2'd0) begin
               ctr_q[x_idx] <= ctr_q[x_idx] - 2'd1;
            end
         end else if (x_taken) begin
            valid_q[x_idx]  <= 1'b1;
            tag_q[x_idx]    <= x_tag;
            target_q[x_idx] <= x_target;
            uncond_q[x_idx] <= x_uncond;
            ctr_q[x_idx]    <= 2'(CTR_ALLOC);
         end
      end
   end

`ifdef BP_STATS_EN
   logic [31:0] stat_br_q, stat_mp_q;

   always_ff @(posedge clock) begin
      if (reset) begin
         stat_br_q <= '0;
         stat_mp_q <= '0;
      end else if (do_update) begin
         stat_br_q <= stat_br_q + 32'd1;
         if (mispredict) stat_mp_q <= stat_mp_q + 32'd1;
      end
   end

   assign stat_branches    = stat_br_q;
   assign stat_mispredicts = stat_mp_q;
`else
   assign stat_branches    = '0;
   assign stat_mispredicts = '0;
`endif

endmodule

// File: tb/tb_branch_predict_unit.sv
// Directed self-checking bench for branch_predict_unit (PC_W=32, ENTRIES=16, CTR_ALLOC=2).
module tb_branch_predict_unit;

   logic        clock;
   logic        reset;
   logic [31:0] f_pc;
   logic        f_pred_taken;
   logic [31:0] f_pred_target;
   logic        x_valid;
   logic [31:0] x_pc;
   logic        x_uncond;
   logic        x_taken;
   logic [31:0] x_target;
   logic        x_pred_taken;
   logic [31:0] x_pred_target;
   logic        stall;
   logic        mispredict;
   logic [31:0] redirect_pc;
   logic [31:0] stat_branches;
   logic [31:0] stat_mispredicts;

   int checks   = 0;
   int failures = 0;
   int exp_br   = 0;
   int exp_mp   = 0;

   branch_predict_unit #(
      .PC_W     (32),
      .ENTRIES  (16),
      .CTR_ALLOC(2)
   ) dut (
      .clock           (clock),
      .reset           (reset),
      .f_pc            (f_pc),
      .f_pred_taken    (f_pred_taken),
      .f_pred_target   (f_pred_target),
      .x_valid         (x_valid),
      .x_pc            (x_pc),
      .x_uncond        (x_uncond),
      .x_taken         (x_taken),
      .x_target        (x_target),
      .x_pred_taken    (x_pred_taken),
      .x_pred_target   (x_pred_target),
      .stall           (stall),
      .mispredict      (mispredict),
      .redirect_pc     (redirect_pc),
      .stat_branches   (stat_branches),
      .stat_mispredicts(stat_mispredicts)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Advance one edge; inputs are set 1ns after an edge, outputs sampled mid-cycle.
   task automatic step();
      if (reset) begin
         exp_br = 0;
         exp_mp = 0;
      end else if (x_valid && !stall) begin
         exp_br++;
         if ((x_taken != x_pred_taken) || (x_taken && x_target != x_pred_target)) exp_mp++;
      end
      @(posedge clock);
      #1;
   endtask

   task automatic resolve(input logic [31:0] pc, input logic unc, input logic tk,
                          input logic [31:0] tgt, input logic ptk, input logic [31:0] ptgt);
      x_valid = 1'b1; x_pc = pc; x_uncond = unc; x_taken = tk; x_target = tgt;
      x_pred_taken = ptk; x_pred_target = ptgt;
   endtask

   task automatic idle();
      x_valid = 1'b0; x_taken = 1'b0; x_uncond = 1'b0;
   endtask

   task automatic check_fetch(input string name, input logic [31:0] pc,
                              input logic exp_tk, input logic [31:0] exp_tgt);
      f_pc = pc;
      #1;
      checks++;
      if (f_pred_taken !== exp_tk || f_pred_target !== exp_tgt) begin
         failures++;
         $display("FAIL %s: pred_taken=%0d target=%0d, expected pred_taken=%0d target=%0d",
                  name, f_pred_taken, f_pred_target, exp_tk, exp_tgt);
      end
   endtask

   task automatic check_res(input string name, input logic exp_mp_v, input logic [31:0] exp_rd);
      #1;
      checks++;
      if (mispredict !== exp_mp_v || redirect_pc !== exp_rd) begin
         failures++;
         $display("FAIL %s: mispredict=%0d redirect=%0d, expected mispredict=%0d redirect=%0d",
                  name, mispredict, redirect_pc, exp_mp_v, exp_rd);
      end
   endtask

   task automatic check_stats(input string name);
      logic [31:0] eb, em;
`ifdef BP_STATS_EN
      eb = 32'(exp_br);
      em = 32'(exp_mp);
`else
      eb = 32'd0;
      em = 32'd0;
`endif
      checks++;
      if (stat_branches !== eb || stat_mispredicts !== em) begin
         failures++;
         $display("FAIL %s: branches=%0d mispredicts=%0d, expected branches=%0d mispredicts=%0d",
                  name, stat_branches, stat_mispredicts, eb, em);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1; stall = 1'b0; f_pc = '0;
      x_pc = '0; x_target = '0; x_pred_target = '0; x_pred_taken = 1'b0;
      idle();
      step(); step();
      reset = 1'b0;
      check_fetch("reset_fetch_5", 32'd5, 1'b0, 32'd6);
      check_fetch("reset_fetch_wrap", 32'hFFFF_FFFF, 1'b0, 32'd0);
      x_pc = 32'd7;
      check_res("idle_redirect", 1'b0, 32'd8);
      check_stats("reset_stats");
   endtask

   task automatic test_allocate();
      resolve(32'd5, 1'b0, 1'b1, 32'd40, 1'b0, 32'd6);
      check_res("alloc_mispredict", 1'b1, 32'd40);
      check_fetch("alloc_read_before_write", 32'd5, 1'b0, 32'd6);
      step();
      idle();
      check_fetch("alloc_visible", 32'd5, 1'b1, 32'd40);
      check_res("alloc_idle_redirect", 1'b0, 32'd6);
   endtask

   task automatic test_train();
      // Taken x3: alloc ctr=2, then 3, then saturate at 3.
      resolve(32'd8, 1'b0, 1'b1, 32'd20, 1'b0, 32'd9);
      step();
      resolve(32'd8, 1'b0, 1'b1, 32'd20, 1'b1, 32'd20);
      check_res("train_correct", 1'b0, 32'd20);
      step();
      resolve(32'd8, 1'b0, 1'b1, 32'd20, 1'b1, 32'd33);
      check_res("train_wrong_target", 1'b1, 32'd20);
      step();
      resolve(32'd8, 1'b0, 1'b0, 32'd20, 1'b1, 32'd20);
      check_res("train_nt_mispredict", 1'b1, 32'd9);
      step();
      idle();
      check_fetch("train_ctr2", 32'd8, 1'b1, 32'd20);
      resolve(32'd8, 1'b0, 1'b0, 32'd20, 1'b1, 32'd20);
      step();
      idle();
      check_fetch("train_ctr1", 32'd8, 1'b0, 32'd9);
      resolve(32'd8, 1'b0, 1'b0, 32'd20, 1'b0, 32'd9);
      check_res("train_nt_correct", 1'b0, 32'd9);
      step();
      // ctr now 0; another not-taken must stay 0, so one taken only reaches 1.
      step();
      resolve(32'd8, 1'b0, 1'b1, 32'd20, 1'b0, 32'd9);
      step();
      idle();
      check_fetch("train_floor", 32'd8, 1'b0, 32'd9);
   endtask

   task automatic test_alias();
      resolve(32'd3, 1'b0, 1'b1, 32'd30, 1'b0, 32'd4);
      step();
      idle();
      check_fetch("alias_first", 32'd3, 1'b1, 32'd30);
      resolve(32'd19, 1'b0, 1'b1, 32'd70, 1'b0, 32'd20);
      step();
      idle();
      check_fetch("alias_evicted", 32'd3, 1'b0, 32'd4);
      check_fetch("alias_new", 32'd19, 1'b1, 32'd70);
   endtask

   task automatic test_jr();
      resolve(32'd10, 1'b1, 1'b1, 32'd50, 1'b0, 32'd11);
      step();
      idle();
      check_fetch("jr_alloc", 32'd10, 1'b1, 32'd50);
      resolve(32'd10, 1'b1, 1'b1, 32'd60, 1'b1, 32'd50);
      check_res("jr_mispredict", 1'b1, 32'd60);
      step();
      idle();
      check_fetch("jr_retarget", 32'd10, 1'b1, 32'd60);
   endtask

   task automatic test_stall();
      resolve(32'd12, 1'b0, 1'b1, 32'd80, 1'b0, 32'd13);
      stall = 1'b1;
      for (int i = 0; i < 3; i++) step();
      check_fetch("stall_no_update", 32'd12, 1'b0, 32'd13);
      check_res("stall_mispredict", 1'b1, 32'd80);
      check_stats("stall_stats_held");
      stall = 1'b0;
      step();
      idle();
      check_fetch("stall_released", 32'd12, 1'b1, 32'd80);
      check_stats("stall_stats_once");
      // Single update left ctr=2; one not-taken drops it below the taken threshold.
      resolve(32'd12, 1'b0, 1'b0, 32'd80, 1'b1, 32'd80);
      step();
      idle();
      check_fetch("stall_single_update", 32'd12, 1'b0, 32'd13);
   endtask

   task automatic test_reset_collision();
      reset = 1'b1;
      resolve(32'd14, 1'b0, 1'b1, 32'd90, 1'b0, 32'd15);
      step();
      reset = 1'b0;
      idle();
      check_fetch("rst_collision_no_alloc", 32'd14, 1'b0, 32'd15);
      check_fetch("rst_collision_cleared", 32'd19, 1'b0, 32'd20);
      check_stats("rst_collision_stats");
   endtask

   initial begin
      test_reset();
      test_allocate();
      test_train();
      test_alias();
      test_jr();
      test_stall();
      test_reset_collision();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/branch_predict_unit.md
Name: branch_predict_unit

Overview:
- Parametrised branch prediction and resolution unit for the 5-stage core.
- Fetch side: direct-mapped branch target buffer (BTB) with 2-bit saturating counters gives a next-PC prediction each cycle.
- Execute side: accepts the resolved outcome of j/jal/jr/bne/blt/bex, flags a mispredict, supplies the redirect PC and trains the table.
- Generalises single-cycle execute-stage branch resolution to predicted fetch with configurable table depth and PC width.

Parameters:
- PC_W, 32, PC width in bits; PC is word-addressed (sequential PC = PC+1).
- ENTRIES, 16, BTB entries; power of 2, minimum 2; IDX_W = log2(ENTRIES).
- CTR_ALLOC, 2, counter value written on allocation (0..3).

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high.
- f_pc  in  PC_W  PC being fetched this cycle.
- f_pred_taken  out  1  prediction: redirect fetch to f_pred_target.
- f_pred_target  out  PC_W  predicted target; f_pc+1 when not taken.
- x_valid  in  1  a control-flow instruction is resolving in execute this cycle.
- x_pc  in  PC_W  PC of the resolving instruction.
- x_uncond  in  1  instruction is j/jal/jr (always taken).
- x_taken  in  1  actual outcome (comparator result for bne/blt/bex).
- x_target  in  PC_W  actual target (T, PC+1+N, or rd value for jr).
- x_pred_taken  in  1  prediction piped from fetch with the instruction.
- x_pred_target  in  PC_W  predicted target piped from fetch.
- stall  in  1  pipeline stall; blocks table update.
- mispredict  out  1  flush F/D and redirect fetch.
- redirect_pc  out  PC_W  correct next PC when mispredict = 1.
- stat_branches  out  32  resolved-branch count (see Optional Feature).
- stat_mispredicts  out  32  mispredict count (see Optional Feature).

Behaviour:
- Entry fields: valid, tag = pc[PC_W-1:IDX_W], target[PC_W], uncond, ctr[2].
- Index = pc[IDX_W-1:0].
- Lookup is combinational from f_pc. hit = valid && tag match.
  - f_pred_taken = hit && (uncond || ctr[1]).
  - f_pred_target = f_pred_taken ? target : f_pc+1; the +1 wraps modulo 2^PC_W.
- Resolution is combinational and independent of stall.
  - mispredict = x_valid && ((x_taken != x_pred_taken) || (x_taken && x_target != x_pred_target)).
  - redirect_pc = x_taken ? x_target : x_pc+1.
  - When x_valid = 0: mispredict = 0 and redirect_pc = x_pc+1.
- Update occurs on the rising clock edge when x_valid && !stall && !reset. Indexing uses x_pc.
  - Hit, taken: ctr saturating increment (3 stays 3); target <= x_target; uncond <= x_uncond.
  - Hit, not taken: ctr saturating decrement (0 stays 0); target is unchanged.
  - Miss, taken: allocate/replace; valid <= 1, tag, target, uncond written; ctr <= CTR_ALLOC.
  - Miss, not taken: no change.
- Same-cycle fetch and update at the same index: fetch sees the pre-update contents (read-before-write). The new contents are visible from the next cycle.
- Reset, synchronous, active-high:
  - All valid bits cleared, all ctr set to 1.
  - stat counters cleared.
  - Post-reset, f_pred_taken = 0 and f_pred_target = f_pc+1.
- Reset asserted in the same cycle as x_valid: reset wins and no entry is written.
- Stalled cycles: a resolution repeated across stalled cycles updates exactly once, on the first non-stalled edge.
- The table and statistics are the only state. All outputs other than the stat counters are combinational from state and inputs.

Optional Feature:
- Macro: BP_STATS_EN.
- Defined:
  - stat_branches increments on each updating cycle (x_valid && !stall).
  - stat_mispredicts increments on those cycles when mispredict = 1.
  - Both are 32-bit and wrap at 2^32 back to 0.
- Undefined: both ports are driven constant 0 and no counter flops are instantiated.

Test Plan:
- Reset, then f_pc=5 -> f_pred_taken=0, f_pred_target=6. Resolve x_pc=5, x_taken=1, x_target=40, x_pred_taken=0 -> mispredict=1, redirect_pc=40. Next cycle f_pc=5 -> predict taken to 40 (ctr=2).
- Train x_pc=8 (bne, conditional) taken three times -> ctr=3. Then not-taken twice -> ctr=1. f_pc=8 -> f_pred_taken=0. The third not-taken resolution with x_pred_taken=0 -> mispredict=0.
- Alias: ENTRIES=16, allocate pc=3 then pc=19, both taken -> pc=19 entry replaces pc=3. f_pc=3 -> miss, f_pred_target=4.
- jr: x_uncond=1, x_pc=10, predicted target 50, actual x_target=60 -> mispredict=1, redirect_pc=60. Table target updated to 60.
- stall=1 held 3 cycles with x_valid=1, then stall=0 -> a single update; with BP_STATS_EN, stat_branches increments by exactly 1.
- Reset asserted together with an allocating resolution -> table stays empty and stat counters read 0 on the next cycle.
